// File: rtl/sha256_quad_sequencer_if.sv
// Signal bundle between the SHA-256 quad sequencer, its K+W source, the fused
// four-round quad and the digest consumer. master = sequencer side.
interface sha256_quad_sequencer_if #(
    parameter int WORDBITS  = 32,
    parameter int HASHWORDS = 8,
    parameter int IDXBITS   = 4
);
    localparam int STATEBITS = WORDBITS * HASHWORDS;

    logic                 start;
    logic                 abort;
    logic [STATEBITS-1:0] h_init;
    logic                 busy;

    logic [IDXBITS-1:0]   kw_idx;
    logic                 kw_valid;
    logic                 kw_ack;
    logic [WORDBITS-1:0]  kw0;
    logic [WORDBITS-1:0]  kw1;
    logic [WORDBITS-1:0]  kw2;
    logic [WORDBITS-1:0]  kw3;

    logic [STATEBITS-1:0] quad_a_h_in;
    logic [WORDBITS-1:0]  quad_kw0;
    logic [WORDBITS-1:0]  quad_kw1;
    logic [WORDBITS-1:0]  quad_kw2;
    logic [WORDBITS-1:0]  quad_kw3;
    logic [STATEBITS-1:0] quad_a_h_out;

    logic [STATEBITS-1:0] digest;
    logic                 digest_valid;
    logic                 digest_ready;

    modport master (
        input  start, abort, h_init, kw_valid, kw0, kw1, kw2, kw3,
               quad_a_h_out, digest_ready,
        output busy, kw_idx, kw_ack, quad_a_h_in,
               quad_kw0, quad_kw1, quad_kw2, quad_kw3, digest, digest_valid
    );

    modport slave (
        output start, abort, h_init, kw_valid, kw0, kw1, kw2, kw3,
               quad_a_h_out, digest_ready,
        input  busy, kw_idx, kw_ack, quad_a_h_in,
               quad_kw0, quad_kw1, quad_kw2, quad_kw3, digest, digest_valid
    );
endinterface

// File: rtl/sha256_quad_sequencer.sv
// Drives one shared four-round SHA-256 quad through NUM_PASSES passes per
// 512-bit block and applies the final feed-forward to produce the digest.
//
// state | meaning
// IDLE  | waiting for start; chaining value captured on acceptance
// ISSUE | requesting K+W words for pass kw_idx; stalls while !kw_valid
// LATCH | quad inputs held stable; quad samples them at the end of this cycle
// CAPT  | quad result valid; fold it back into the working state
// FINAL | per-word feed-forward add into the digest register
// DONE  | digest presented until the consumer accepts it
module sha256_quad_sequencer #(
    parameter int WORDBITS   = 32,
    parameter int HASHWORDS  = 8,
    parameter int NUM_PASSES = 16,
    parameter int IDXBITS    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sha256_quad_sequencer_if.master bus
);
    localparam int STATEBITS = WORDBITS * HASHWORDS;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_CAPT  = 3'd3;
    localparam logic [2:0] S_FINAL = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [IDXBITS-1:0] LAST_IDX = IDXBITS'(NUM_PASSES - 1);

    logic [2:0]           state_q, state_d;
    logic [IDXBITS-1:0]   kw_idx_q, kw_idx_d;
    logic [STATEBITS-1:0] hinit_q, hinit_d;
    logic [STATEBITS-1:0] quad_a_h_in_q, quad_a_h_in_d;
    logic [WORDBITS-1:0]  quad_kw0_q, quad_kw0_d;
    logic [WORDBITS-1:0]  quad_kw1_q, quad_kw1_d;
    logic [WORDBITS-1:0]  quad_kw2_q, quad_kw2_d;
    logic [WORDBITS-1:0]  quad_kw3_q, quad_kw3_d;
    logic [STATEBITS-1:0] digest_q, digest_d;
    logic                 digest_valid_q, digest_valid_d;
    logic [STATEBITS-1:0] feed_fwd;

    // Word-wise modular add: carries must not cross word boundaries.
    for (genvar i = 0; i < HASHWORDS; i++) begin : g_ffwd
        assign feed_fwd[i*WORDBITS +: WORDBITS] =
            hinit_q[i*WORDBITS +: WORDBITS] + quad_a_h_in_q[i*WORDBITS +: WORDBITS];
    end

    always_comb begin
        state_d        = state_q;
        kw_idx_d       = kw_idx_q;
        hinit_d        = hinit_q;
        quad_a_h_in_d  = quad_a_h_in_q;
        quad_kw0_d     = quad_kw0_q;
        quad_kw1_d     = quad_kw1_q;
        quad_kw2_d     = quad_kw2_q;
        quad_kw3_d     = quad_kw3_q;
        digest_d       = digest_q;
        digest_valid_d = digest_valid_q;

        if (bus.abort && (state_q != S_IDLE)) begin
            state_d        = S_IDLE;
            kw_idx_d       = '0;
            digest_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        hinit_d       = bus.h_init;
                        quad_a_h_in_d = bus.h_init;
                        kw_idx_d      = '0;
                        state_d       = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.kw_valid) begin
                        quad_kw0_d = bus.kw0;
                        quad_kw1_d = bus.kw1;
                        quad_kw2_d = bus.kw2;
                        quad_kw3_d = bus.kw3;
                        state_d    = S_LATCH;
                    end
                end
                S_LATCH: state_d = S_CAPT;
                S_CAPT: begin
                    quad_a_h_in_d = bus.quad_a_h_out;
                    if (kw_idx_q == LAST_IDX) begin
                        state_d = S_FINAL;
                    end else begin
                        kw_idx_d = kw_idx_q + 1'b1;
                        state_d  = S_ISSUE;
                    end
                end
                S_FINAL: begin
                    digest_d       = feed_fwd;
                    digest_valid_d = 1'b1;
                    state_d        = S_DONE;
                end
                S_DONE: begin
                    if (bus.digest_ready) begin
                        digest_valid_d = 1'b0;
                        state_d        = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            kw_idx_q       <= '0;
            hinit_q        <= '0;
            quad_a_h_in_q  <= '0;
            quad_kw0_q     <= '0;
            quad_kw1_q     <= '0;
            quad_kw2_q     <= '0;
            quad_kw3_q     <= '0;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            kw_idx_q       <= kw_idx_d;
            hinit_q        <= hinit_d;
            quad_a_h_in_q  <= quad_a_h_in_d;
            quad_kw0_q     <= quad_kw0_d;
            quad_kw1_q     <= quad_kw1_d;
            quad_kw2_q     <= quad_kw2_d;
            quad_kw3_q     <= quad_kw3_d;
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
        end
    end

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.kw_ack       = (state_q == S_ISSUE) && bus.kw_valid && !bus.abort;
    assign bus.kw_idx       = kw_idx_q;
    assign bus.quad_a_h_in  = quad_a_h_in_q;
    assign bus.quad_kw0     = quad_kw0_q;
    assign bus.quad_kw1     = quad_kw1_q;
    assign bus.quad_kw2     = quad_kw2_q;
    assign bus.quad_kw3     = quad_kw3_q;
    assign bus.digest       = digest_q;
    assign bus.digest_valid = digest_valid_q;
endmodule

// File: tb/tb_sha256_quad_sequencer.sv
// Bench for sha256_quad_sequencer: models the quad and the "abc" K+W source,
// scoreboards expected digests and checks timing, stalls, abort and reset.
module tb_sha256_quad_sequencer;
    localparam int WB = 32;
    localparam int IB = 4;
    localparam int SB = 256;

    localparam logic [SB-1:0] IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
    localparam logic [SB-1:0] ABC = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                                     32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sha256_quad_sequencer_if #(.WORDBITS(WB), .HASHWORDS(8), .IDXBITS(IB)) bus ();

    sha256_quad_sequencer #(.WORDBITS(WB), .HASHWORDS(8), .NUM_PASSES(16), .IDXBITS(IB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;
    logic [SB-1:0] exp_q [$];
    logic [31:0] kw_tab [64];
    logic [SB-1:0] quad_q;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [SB-1:0] round1(input logic [SB-1:0] s, input logic [31:0] kw);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        a = s[31:0];    b = s[63:32];   c = s[95:64];   d = s[127:96];
        e = s[159:128]; f = s[191:160]; g = s[223:192]; h = s[255:224];
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + kw;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {g, f, e, d + t1, c, b, a, t1 + t2};
    endfunction

    function automatic logic [SB-1:0] quad4(input logic [SB-1:0] s, input logic [31:0] k0,
                                            input logic [31:0] k1, input logic [31:0] k2,
                                            input logic [31:0] k3);
        return round1(round1(round1(round1(s, k0), k1), k2), k3);
    endfunction

    function automatic logic [SB-1:0] compress(input logic [SB-1:0] h);
        logic [SB-1:0] s, r;
        s = h;
        for (int t = 0; t < 64; t++) s = round1(s, kw_tab[t]);
        for (int i = 0; i < 8; i++) r[32*i +: 32] = h[32*i +: 32] + s[32*i +: 32];
        return r;
    endfunction

    // K+W for the padded "abc" block
    initial begin
        logic [31:0] w [64];
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) w[t] = 32'h0;
        w[0]  = 32'h61626380;
        w[15] = 32'h00000018;
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int t = 0; t < 64; t++) kw_tab[t] = K[t] + w[t];
    end

    assign bus.kw0 = kw_tab[{bus.kw_idx, 2'd0}];
    assign bus.kw1 = kw_tab[{bus.kw_idx, 2'd1}];
    assign bus.kw2 = kw_tab[{bus.kw_idx, 2'd2}];
    assign bus.kw3 = kw_tab[{bus.kw_idx, 2'd3}];

    // Input-registered quad model
    always @(posedge clk)
        quad_q <= quad4(bus.quad_a_h_in, bus.quad_kw0, bus.quad_kw1, bus.quad_kw2, bus.quad_kw3);
    assign bus.quad_a_h_out = quad_q;

    // Starts one block and runs until digest_valid, an abort point (returns in
    // LATCH with abort driven) or a reset point (returns in CAPT).
    task automatic run_block(input logic [SB-1:0] h, input bit stall_en, input bit start_pulse_en,
                             input int abort_idx, input int rst_idx,
                             output int lat, output int acks, output logic [SB-1:0] dig,
                             output bit done);
        int stall_cnt;
        bit acked_prev, rst_wait;
        logic [IB-1:0] prev_idx, ack_idx;
        stall_cnt = 0; rst_wait = 0; lat = 0; acks = 0; dig = '0; done = 0;
        bus.h_init = h; bus.kw_valid = 1'b1; bus.digest_ready = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        prev_idx = bus.kw_idx;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            acked_prev = bus.kw_ack;
            ack_idx = bus.kw_idx;
            if (bus.kw_ack) acks++;
            @(posedge clk); #1;
            lat++;
            bus.start = 1'b0;
            if (stall_cnt > 0) stall_cnt--;
            if (stall_en && bus.kw_idx != prev_idx) begin
                if (bus.kw_idx == 3) stall_cnt = 5;
                else if (bus.kw_idx == 15) stall_cnt = 1;
            end
            bus.kw_valid = (stall_cnt == 0);
            if (start_pulse_en && bus.kw_idx != prev_idx && bus.kw_idx == 7) bus.start = 1'b1;
            prev_idx = bus.kw_idx;
            if (rst_wait) return;
            if (acked_prev && int'(ack_idx) == rst_idx) rst_wait = 1;
            if (acked_prev && int'(ack_idx) == abort_idx) begin
                bus.abort = 1'b1;
                return;
            end
            if (bus.digest_valid) begin
                dig = bus.digest;
                done = 1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.h_init = '0;
        bus.kw_valid = 1'b1; bus.digest_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", bus.busy); else passed++;
        checks++; if (bus.kw_idx !== '0) $display("FAIL rst_kw_idx got=%0d exp=0", bus.kw_idx); else passed++;
        checks++; if (bus.digest_valid !== 1'b0) $display("FAIL rst_dvalid got=%b exp=0", bus.digest_valid); else passed++;
        checks++; if (bus.digest !== '0) $display("FAIL rst_digest got=%h exp=0", bus.digest); else passed++;
        checks++; if (bus.quad_a_h_in !== '0) $display("FAIL rst_quad_in got=%h exp=0", bus.quad_a_h_in); else passed++;
        checks++; if (bus.kw_ack !== 1'b0) $display("FAIL rst_kw_ack got=%b exp=0", bus.kw_ack); else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_abc();
        int lat, acks; logic [SB-1:0] dig, exp; bit done;
        exp_q.push_back(ABC);
        run_block(IV, 0, 0, -1, -1, lat, acks, dig, done);
        checks++; if (done !== 1'b1) $display("FAIL abc_done timeout lat=%0d exp=49", lat); else passed++;
        exp = exp_q.pop_front();
        checks++; if (dig !== exp) $display("FAIL abc_digest got=%h exp=%h", dig, exp); else passed++;
        checks++; if (lat !== 49) $display("FAIL abc_latency got=%0d exp=49", lat); else passed++;
        checks++; if (acks !== 16) $display("FAIL abc_acks got=%0d exp=16", acks); else passed++;
        bus.digest_ready = 1'b1;
        @(posedge clk); #1;
        bus.digest_ready = 1'b0;
        checks++; if (bus.digest_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL abc_handshake valid=%b busy=%b exp=0/0", bus.digest_valid, bus.busy); else passed++;
        checks++; if (bus.digest !== exp) $display("FAIL abc_retain got=%h exp=%h", bus.digest, exp); else passed++;
    endtask

    task automatic test_stall();
        int lat, acks; logic [SB-1:0] dig, exp; bit done;
        exp_q.push_back(ABC);
        run_block(IV, 1, 0, -1, -1, lat, acks, dig, done);
        exp = exp_q.pop_front();
        checks++; if (done !== 1'b1 || dig !== exp) $display("FAIL stall_digest got=%h exp=%h", dig, exp); else passed++;
        checks++; if (lat !== 55) $display("FAIL stall_latency got=%0d exp=55", lat); else passed++;
        checks++; if (acks !== 16) $display("FAIL stall_acks got=%0d exp=16", acks); else passed++;
        bus.digest_ready = 1'b1;
        @(posedge clk); #1;
        bus.digest_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat, acks; logic [SB-1:0] dig, exp, first; bit done;
        exp_q.push_back(ABC);
        run_block(IV, 0, 0, -1, -1, lat, acks, dig, done);
        first = exp_q.pop_front();
        checks++; if (done !== 1'b1 || dig !== first) $display("FAIL bp_digest got=%h exp=%h", dig, first); else passed++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.digest !== first || bus.digest_valid !== 1'b1 || bus.busy !== 1'b1)
                $display("FAIL bp_hold cyc=%0d digest=%h valid=%b busy=%b exp=%h/1/1",
                         i, bus.digest, bus.digest_valid, bus.busy, first);
            else passed++;
        end
        bus.digest_ready = 1'b1;
        @(posedge clk); #1;
        bus.digest_ready = 1'b0;
        checks++; if (bus.digest_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL bp_release valid=%b busy=%b exp=0/0", bus.digest_valid, bus.busy); else passed++;
        exp_q.push_back(compress(dig));
        run_block(dig, 0, 0, -1, -1, lat, acks, dig, done);
        exp = exp_q.pop_front();
        checks++; if (done !== 1'b1 || dig !== exp) $display("FAIL chain_digest got=%h exp=%h", dig, exp); else passed++;
        checks++; if (lat !== 49) $display("FAIL chain_latency got=%0d exp=49", lat); else passed++;
        bus.digest_ready = 1'b1;
        @(posedge clk); #1;
        bus.digest_ready = 1'b0;
    endtask

    task automatic test_start_ignored();
        int lat, acks; logic [SB-1:0] dig, exp; bit done;
        exp_q.push_back(ABC);
        run_block(IV, 0, 1, -1, -1, lat, acks, dig, done);
        exp = exp_q.pop_front();
        checks++; if (done !== 1'b1 || dig !== exp) $display("FAIL busy_start_digest got=%h exp=%h", dig, exp); else passed++;
        checks++; if (lat !== 49) $display("FAIL busy_start_latency got=%0d exp=49", lat); else passed++;
        @(posedge clk); #1;
        bus.h_init = ~IV;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.digest_valid !== 1'b1 || bus.digest !== exp)
            $display("FAIL done_start busy=%b valid=%b digest=%h exp=1/1/%h",
                     bus.busy, bus.digest_valid, bus.digest, exp); else passed++;
        bus.digest_ready = 1'b1;
        @(posedge clk); #1;
        bus.digest_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL done_start_idle busy got=%b exp=0", bus.busy); else passed++;
    endtask

    task automatic test_abort();
        int lat, acks; logic [SB-1:0] dig, exp; bit done;
        bus.h_init = IV; bus.kw_valid = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b1;
        #1;
        checks++; if (bus.kw_ack !== 1'b0) $display("FAIL abort_ack_mask got=%b exp=0", bus.kw_ack); else passed++;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        checks++; if (bus.busy !== 1'b0) $display("FAIL abort_issue busy got=%b exp=0", bus.busy); else passed++;
        run_block(IV, 0, 0, 9, -1, lat, acks, dig, done);
        checks++; if (bus.abort !== 1'b1) $display("FAIL abort_reach no LATCH at idx 9 lat=%0d", lat); else passed++;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.digest_valid !== 1'b0 || bus.kw_idx !== '0)
            $display("FAIL abort_latch busy=%b valid=%b kw_idx=%0d exp=0/0/0",
                     bus.busy, bus.digest_valid, bus.kw_idx); else passed++;
        exp_q.push_back(ABC);
        run_block(IV, 0, 0, -1, -1, lat, acks, dig, done);
        exp = exp_q.pop_front();
        checks++; if (done !== 1'b1 || dig !== exp) $display("FAIL abort_rerun got=%h exp=%h", dig, exp); else passed++;
        bus.digest_ready = 1'b1;
        @(posedge clk); #1;
        bus.digest_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat, acks; logic [SB-1:0] dig, exp; bit done;
        run_block(IV, 0, 0, -1, 12, lat, acks, dig, done);
        checks++; if (bus.busy !== 1'b1 || bus.kw_idx !== 4'd12)
            $display("FAIL rst_mid_reach busy=%b kw_idx=%0d exp=1/12", bus.busy, bus.kw_idx); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.kw_idx !== '0 || bus.digest_valid !== 1'b0)
            $display("FAIL rst_mid_ctrl busy=%b kw_idx=%0d valid=%b exp=0/0/0",
                     bus.busy, bus.kw_idx, bus.digest_valid); else passed++;
        checks++; if (bus.digest !== '0 || bus.quad_a_h_in !== '0)
            $display("FAIL rst_mid_data digest=%h quad_in=%h exp=0/0", bus.digest, bus.quad_a_h_in); else passed++;
        checks++; if ({bus.quad_kw0, bus.quad_kw1, bus.quad_kw2, bus.quad_kw3} !== '0)
            $display("FAIL rst_mid_kw got=%h exp=0",
                     {bus.quad_kw0, bus.quad_kw1, bus.quad_kw2, bus.quad_kw3}); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(ABC);
        run_block(IV, 0, 0, -1, -1, lat, acks, dig, done);
        exp = exp_q.pop_front();
        checks++; if (done !== 1'b1 || dig !== exp) $display("FAIL rst_mid_rerun got=%h exp=%h", dig, exp); else passed++;
        checks++; if (lat !== 49) $display("FAIL rst_mid_latency got=%0d exp=49", lat); else passed++;
        bus.digest_ready = 1'b1;
        @(posedge clk); #1;
        bus.digest_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_abc();
        test_stall();
        test_back_to_back();
        test_start_ignored();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
